// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature target: FSM states, register
// addresses and the read-side register mux.
package i2c_pkg;

  localparam logic [3:0] REG_TEMP_MSB = 4'h0;
  localparam logic [3:0] REG_TEMP_LSB = 4'h1;
  localparam logic [3:0] REG_STATUS   = 4'h2;
  localparam logic [3:0] REG_CFG      = 4'h3;
  localparam logic [3:0] REG_ID       = 4'hB;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_t;

  function automatic logic [7:0] reg_read(input logic [3:0]  ptr,
                                          input logic [15:0] snapshot,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  id);
    case (ptr)
      REG_TEMP_MSB: reg_read = snapshot[15:8];
      REG_TEMP_LSB: reg_read = snapshot[7:0];
      REG_STATUS:   reg_read = 8'h00;
      REG_CFG:      reg_read = cfg;
      REG_ID:       reg_read = id;
      default:      reg_read = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus a history stage for edge and
// START/STOP condition pulses in the system clock domain.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_sync,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  logic [2:0] scl_q, sda_q;

  // Idle bus is high; resetting to 1 avoids a phantom START after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign sda_sync = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating the ADT7420 register map: address match, pointer and
// cfg writes, and reads of a per-transaction temperature snapshot.
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = 7'h4B,
  parameter logic [7:0] DEVICE_ID = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_en,
  input  logic [15:0] temp,
  output logic [7:0]  cfg,
  output logic        snap
);

  logic sda, start, stop, scl_rise, scl_fall;

  i2c_bus_sync u_sync (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in),
    .sda_sync(sda), .start(start), .stop(stop),
    .scl_rise(scl_rise), .scl_fall(scl_fall)
  );

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, ptr, ptr_n;
  logic [7:0]  shreg, shreg_n, cfg_n, rd_byte, rd_next;
  logic [15:0] snapshot, snapshot_n;
  logic        rw, rw_n, sda_en_n, snap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ptr      <= 4'd0;
      shreg    <= 8'h00;
      cfg      <= 8'h00;
      snapshot <= 16'h0000;
      rw       <= 1'b0;
      sda_en   <= 1'b0;
      snap     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      shreg    <= shreg_n;
      cfg      <= cfg_n;
      snapshot <= snapshot_n;
      rw       <= rw_n;
      sda_en   <= sda_en_n;
      snap     <= snap_n;
    end
  end

  assign rd_byte = reg_read(ptr, snapshot, cfg, DEVICE_ID);
  assign rd_next = reg_read(ptr + 4'd1, snapshot, cfg, DEVICE_ID);

  // Bits are sampled on SCL rise; all SDA drive changes happen on SCL fall.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ptr_n      = ptr;
    shreg_n    = shreg;
    cfg_n      = cfg;
    snapshot_n = snapshot;
    rw_n       = rw;
    sda_en_n   = sda_en;
    snap_n     = 1'b0;
    if (start) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      sda_en_n = 1'b0;
    end else if (stop) begin
      state_n  = IDLE;
      sda_en_n = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR, PTR, WDATA: begin
          shreg_n = {shreg[6:0], sda};
          cnt_n   = cnt + 4'd1;
        end
        RDATA:   cnt_n = cnt + 4'd1;
        // cnt doubles as the "initiator ACKed" flag while in RACK
        RACK:    if (sda) state_n = WAIT; else cnt_n = 4'd1;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: if (cnt == 4'd8) begin
          if (shreg[7:1] == I2C_ADDR) begin
            state_n  = ADDR_ACK;
            sda_en_n = 1'b1;
            rw_n     = shreg[0];
            if (shreg[0]) begin
              snap_n     = 1'b1;
              snapshot_n = temp;
            end
          end else begin
            state_n = WAIT;
          end
        end
        ADDR_ACK: begin
          cnt_n = 4'd0;
          if (rw) begin
            state_n  = RDATA;
            shreg_n  = rd_byte;
            sda_en_n = ~rd_byte[7];
          end else begin
            state_n  = PTR;
            sda_en_n = 1'b0;
          end
        end
        PTR: if (cnt == 4'd8) begin
          ptr_n    = shreg[3:0];
          sda_en_n = 1'b1;
          state_n  = PTR_ACK;
        end
        WDATA: if (cnt == 4'd8) begin
          if (ptr == REG_CFG) cfg_n = shreg;
          ptr_n    = ptr + 4'd1;
          sda_en_n = 1'b1;
          state_n  = WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          state_n  = WDATA;
          cnt_n    = 4'd0;
          sda_en_n = 1'b0;
        end
        RDATA: if (cnt == 4'd8) begin
          state_n  = RACK;
          cnt_n    = 4'd0;
          sda_en_n = 1'b0;
        end else begin
          shreg_n  = {shreg[6:0], 1'b0};
          sda_en_n = ~shreg[6];
        end
        RACK: if (cnt == 4'd1) begin
          ptr_n    = ptr + 4'd1;
          shreg_n  = rd_next;
          sda_en_n = ~rd_next[7];
          cnt_n    = 4'd0;
          state_n  = RDATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Directed bench: a bit-banged I2C initiator drives the target over an
// open-drain bus model; expected bytes and flags are hand-computed.
module tb_i2c_temp_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_in, sda_en, snap;
  logic [15:0] temp = 16'h0000;
  logic [7:0]  cfg;

  int checks = 0;
  int errors = 0;
  int snap_cnt = 0;
  int en_cnt = 0;

  assign sda_in = m_sda & ~sda_en;

  i2c_temp_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in),
    .sda_en(sda_en), .temp(temp), .cfg(cfg), .snap(snap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (snap)   snap_cnt = snap_cnt + 1;
    if (sda_en) en_cnt   = en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wq;
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wq;
    scl = 1'b1;   wq;
    m_sda = 1'b0; wq;
    scl = 1'b0;   wq;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wq;
    scl = 1'b1;   wq;
    m_sda = 1'b1; wq;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;  wq;
    scl = 1'b1; wq; wq;
    scl = 1'b0; wq;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq;
    scl = 1'b1;   wq;
    b = sda_in;   wq;
    scl = 1'b0;   wq;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  logic       ack;
  logic [7:0] d;
  int         snap0, en0;

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_sda_en", {15'd0, sda_en}, 16'd0);
    chk("rst_cfg", {8'd0, cfg}, 16'h0000);
    chk("rst_snap", {15'd0, snap}, 16'd0);
    rst = 1'b0;
    wq;

    // device id via pointer 0x0B and repeated START
    i2c_start;
    write_byte(8'h96, ack); chk("id_aw_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h0B, ack); chk("id_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_start;
    write_byte(8'h97, ack); chk("id_ar_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b1, d);     chk("id_byte", {8'd0, d}, 16'h00CB);
    i2c_stop;

    // two-byte temperature read, one snap pulse
    temp = 16'h0A40;
    i2c_start;
    write_byte(8'h96, ack); chk("t_aw_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h00, ack); chk("t_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_start;
    snap0 = snap_cnt;
    write_byte(8'h97, ack); chk("t_ar_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b0, d);     chk("t_msb", {8'd0, d}, 16'h000A);
    read_byte(1'b1, d);     chk("t_lsb", {8'd0, d}, 16'h0040);
    i2c_stop;
    chk("t_snap_once", 16'(snap_cnt - snap0), 16'd1);

    // wrong address: never drives SDA
    en0 = en_cnt;
    i2c_start;
    write_byte(8'h90, ack); chk("bad_addr_nack", {15'd0, ack}, 16'd1);
    write_byte(8'h00, ack); chk("bad_data_nack", {15'd0, ack}, 16'd1);
    i2c_stop;
    chk("bad_no_drive", 16'(en_cnt - en0), 16'd0);
    // pointer left at 1 by the ACK/NACK read above
    i2c_start;
    write_byte(8'h97, ack); chk("after_bad_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b1, d);     chk("ptr_persist", {8'd0, d}, 16'h0040);
    i2c_stop;

    // cfg write and readback; non-writable register discarded
    i2c_start;
    write_byte(8'h96, ack);
    write_byte(8'h03, ack);
    write_byte(8'h80, ack); chk("cfg_wr_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h55, ack); chk("ro_wr_ack", {15'd0, ack}, 16'd0);
    i2c_stop;
    chk("cfg_val", {8'd0, cfg}, 16'h0080);
    i2c_start;
    write_byte(8'h96, ack);
    write_byte(8'h03, ack);
    i2c_start;
    write_byte(8'h97, ack);
    read_byte(1'b0, d);     chk("cfg_rd", {8'd0, d}, 16'h0080);
    read_byte(1'b1, d);     chk("reg4_rd", {8'd0, d}, 16'h0000);
    i2c_stop;

    // pointer wraps 0x0F -> 0x00
    i2c_start;
    write_byte(8'h96, ack);
    write_byte(8'h0F, ack);
    i2c_start;
    write_byte(8'h97, ack);
    read_byte(1'b0, d);     chk("wrap_0f", {8'd0, d}, 16'h0000);
    read_byte(1'b1, d);     chk("wrap_00", {8'd0, d}, 16'h000A);
    i2c_stop;

    // coherent snapshot across a temp change mid-read
    i2c_start;
    write_byte(8'h96, ack);
    write_byte(8'h00, ack);
    i2c_start;
    write_byte(8'h97, ack);
    read_byte(1'b0, d);     chk("coh_msb", {8'd0, d}, 16'h000A);
    temp = 16'h0B00;
    read_byte(1'b1, d);     chk("coh_lsb", {8'd0, d}, 16'h0040);
    i2c_stop;

    // reset while driving a 0 data bit (status register reads 0x00)
    i2c_start;
    write_byte(8'h96, ack);
    write_byte(8'h02, ack);
    i2c_start;
    write_byte(8'h97, ack);
    wq;
    chk("rd_drive0", {15'd0, sda_en}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_release", {15'd0, sda_en}, 16'd0);
    wq;
    m_sda = 1'b1; wq;
    scl = 1'b1;   wq;
    rst = 1'b0;   wq;
    chk("rst_cfg2", {8'd0, cfg}, 16'h0000);
    temp = 16'h1234;
    i2c_start;
    write_byte(8'h97, ack); chk("rst_ar_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b1, d);     chk("rst_ptr0", {8'd0, d}, 16'h0012);
    i2c_stop;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
